// File: rtl/mem_stage.sv
// mem_stage -- MEM stage of the 5-stage MIPS pipeline.
//
// Holds the EX/MEM pipeline register, runs the request/ack handshake with
// data memory for loads and stores, stalls upstream while an access is
// outstanding, resolves branches and presents WB-facing results and tags.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access that has gone
// TIMEOUT_CYCLES request cycles without ack (sets sticky mem_err). Without
// it the request waits forever and mem_err is tied 0. The TIMEOUT_CYCLES /
// CNT_W parameters only exist in the timeout build.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ex_*, EXE_ins_*              everything the EX stage drives
//   dmem_req/we/addr/wdata       request side of the memory handshake
//   dmem_ack/rdata               completion and load data from memory
//   mem_stall                    freezes PC, IF/ID, ID/EXE and EX/MEM
//   mem_pcsrc, mem_branch_pc     branch resolution
//   mem_wreg/m2reg/aluR/mdata/destR, MEM_ins_*  results toward WB
//   mem_err                      sticky timeout flag
module mem_stage
`ifdef MEM_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4   // needs 2**CNT_W > TIMEOUT_CYCLES
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic        ex_wmem,
  input  logic [31:0] ex_aluR,
  input  logic [31:0] ex_inB,
  input  logic [4:0]  ex_destR,
  input  logic        ex_branch,
  input  logic        ex_zero,
  input  logic [31:0] ex_pc,
  input  logic [3:0]  EXE_ins_type,
  input  logic [3:0]  EXE_ins_number,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_pcsrc,
  output logic [31:0] mem_branch_pc,
  output logic        mem_wreg,
  output logic        mem_m2reg,
  output logic [31:0] mem_aluR,
  output logic [31:0] mem_mdata,
  output logic [4:0]  mem_destR,
  output logic [3:0]  MEM_ins_type,
  output logic [3:0]  MEM_ins_number,
  output logic        mem_err
);

  typedef enum logic {S_IDLE, S_REQ} state_e;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [31:0] aluR;
    logic [31:0] inB;
    logic [4:0]  destR;
    logic        branch;
    logic        zero;
    logic [31:0] pc;
    logic [3:0]  ins_type;
    logic [3:0]  ins_number;
  } exmem_t;

  exmem_t m_q, m_d;
  state_e state_q, state_d;
  logic   err_q, err_d;
  logic   abort, req, stall;

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // After TIMEOUT_CYCLES unacked request cycles the access is abandoned:
  // request and stall both drop so the pipeline moves on.
  assign abort = (state_q == S_REQ) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
  assign abort = 1'b0;
`endif

  assign req   = (state_q == S_REQ) && !abort;
  assign stall = req && !dmem_ack;

  always_comb begin
    m_d     = m_q;
    state_d = state_q;
    err_d   = err_q | abort;
    if (!stall) begin
      m_d = '{wreg: ex_wreg, m2reg: ex_m2reg, wmem: ex_wmem, aluR: ex_aluR,
              inB: ex_inB, destR: ex_destR, branch: ex_branch, zero: ex_zero,
              pc: ex_pc, ins_type: EXE_ins_type, ins_number: EXE_ins_number};
      // Entering REQ straight from REQ gives back-to-back memops no gap.
      state_d = (ex_wmem || ex_m2reg) ? S_REQ : S_IDLE;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Only stall cycles count; any capture (ack, abort, non-memop) clears.
  always_comb begin
    cnt_d = stall ? cnt_q + CNT_W'(1) : '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q     <= '0;
      state_q <= S_IDLE;
      err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      m_q     <= m_d;
      state_q <= state_d;
      err_q   <= err_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign dmem_req       = req;
  assign dmem_we        = m_q.wmem;
  assign dmem_addr      = m_q.aluR;
  assign dmem_wdata     = m_q.inB;
  assign mem_stall      = stall;
  assign mem_pcsrc      = m_q.branch & m_q.zero;
  assign mem_branch_pc  = m_q.pc;
  // Suppressed while waiting and for an aborted access.
  assign mem_wreg       = m_q.wreg & !stall & !abort;
  // Store wins when both store and load are flagged.
  assign mem_m2reg      = m_q.m2reg & !m_q.wmem;
  assign mem_aluR       = m_q.aluR;
  // Read data is only meaningful in the ack cycle; zero otherwise.
  assign mem_mdata      = (req && dmem_ack) ? dmem_rdata : '0;
  assign mem_destR      = m_q.destR;
  assign MEM_ins_type   = m_q.ins_type;
  assign MEM_ins_number = m_q.ins_number;
  assign mem_err        = err_q;

endmodule
